// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: finds the lowest-index sprite slot covering the current pixel,
// reads its colour from sprite memory and muxes it over the background.
// Optional: define SPRITE_TRANSPARENCY_EN to make TRANSPARENT_COLOR see-through.
module sprite_pixel_fetch #(
  parameter int unsigned N_SLOTS = 4,
  parameter int unsigned SPRITE_SIZE = 20,
  parameter int unsigned COLOR_W = 9,
  parameter int unsigned ADDR_W = 14,
  parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = 9'h1FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               refresh_data_in,
  input  logic               refresh_vga_in,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               wr_en,
  input  logic [2:0]         wr_slot,
  input  logic [25:0]        wr_data,
  input  logic [COLOR_W-1:0] bg_color,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [COLOR_W-1:0] mem_data,
  output logic [COLOR_W-1:0] color_out,
  output logic               color_valid
);

  typedef enum logic [1:0] {StIdle, StAddr, StRead, StHold} state_e;

  localparam int unsigned SqArea = SPRITE_SIZE * SPRITE_SIZE;
`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TranspEn = 1'b1;
`else
  localparam bit TranspEn = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [25:0]         slot_q [N_SLOTS];
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_rd_q;
  logic                hit_q;
  logic [COLOR_W-1:0]  sprite_q;
  logic [COLOR_W-1:0]  color_q;
  logic                valid_q;

  logic                any_hit;
  logic [25:0]         win;
  logic [9:0]          dx, dy;
  logic [ADDR_W-1:0]   addr_calc;
  logic                visible;

  // Slot fields: {enable, offset[4:0], sy[9:0], sx[9:0]}; ends use 11 bits so 1023+ never wraps
  function automatic logic slot_hit(input logic [25:0] s, input logic [9:0] px,
                                    input logic [9:0] py);
    logic [10:0] x_end, y_end;
    x_end = {1'b0, s[9:0]} + 11'(SPRITE_SIZE);
    y_end = {1'b0, s[19:10]} + 11'(SPRITE_SIZE);
    return s[25] && (px >= s[9:0]) && ({1'b0, px} < x_end) &&
           (py >= s[19:10]) && ({1'b0, py} < y_end);
  endfunction

  always_comb begin
    any_hit = 1'b0;
    win     = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (!any_hit && slot_hit(slot_q[i], pixel_x, pixel_y)) begin
        any_hit = 1'b1;
        win     = slot_q[i];
      end
    end
  end

  assign dx        = pixel_x - win[9:0];
  assign dy        = pixel_y - win[19:10];
  assign addr_calc = ADDR_W'(32'(win[24:20]) * SqArea + 32'(dy) * SPRITE_SIZE + 32'(dx));
  assign visible   = !(TranspEn && (sprite_q == TRANSPARENT_COLOR));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (refresh_data_in) state_d = StAddr;
      StAddr:  state_d = StRead;
      StRead:  state_d = refresh_data_in ? StHold : StIdle;
      StHold:  if (!refresh_data_in) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      for (int unsigned i = 0; i < N_SLOTS; i++) slot_q[i] <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      hit_q      <= 1'b0;
      sprite_q   <= '0;
      color_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        if (wr_en && (wr_slot == 3'(i))) slot_q[i] <= wr_data;
      end
      mem_rd_q <= 1'b0;
      // A new lookup takes priority over the post-output clear so a back-to-back pixel keeps its hit
      if (state_q == StAddr) begin
        hit_q <= any_hit;
        if (any_hit) begin
          mem_addr_q <= addr_calc;
          mem_rd_q   <= 1'b1;
        end
      end else if (valid_q) begin
        hit_q <= 1'b0;
      end
      if (state_q == StRead) sprite_q <= mem_data;
      valid_q <= refresh_vga_in;
      if (refresh_vga_in) color_q <= (hit_q && visible) ? sprite_q : bg_color;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign color_out   = color_q;
  assign color_valid = valid_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch: vector table of pixels plus hand-written
// sequences for overlapping strobes, hold, slot writes and mid-pixel reset.
module tb_sprite_pixel_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        refresh_data_in, refresh_vga_in;
  logic [9:0]  pixel_x, pixel_y;
  logic        wr_en;
  logic [2:0]  wr_slot;
  logic [25:0] wr_data;
  logic [8:0]  bg_color;
  logic [13:0] mem_addr;
  logic        mem_rd;
  logic [8:0]  mem_data;
  logic [8:0]  color_out;
  logic        color_valid;

  int total = 0;
  int bad   = 0;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam logic [8:0] TranspExp = 9'h007;
`else
  localparam logic [8:0] TranspExp = 9'h1FF;
`endif

  sprite_pixel_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .refresh_data_in (refresh_data_in),
    .refresh_vga_in  (refresh_vga_in),
    .pixel_x         (pixel_x),
    .pixel_y         (pixel_y),
    .wr_en           (wr_en),
    .wr_slot         (wr_slot),
    .wr_data         (wr_data),
    .bg_color        (bg_color),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_data        (mem_data),
    .color_out       (color_out),
    .color_valid     (color_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x, y;
    logic [8:0]  md, bg;
    int          rd;
    logic [13:0] addr;
    logic [8:0]  color;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input logic [2:0] idx, input logic en, input logic [4:0] off,
                            input logic [9:0] sx, input logic [9:0] sy);
    wr_en = 1'b1; wr_slot = idx; wr_data = {en, off, sy, sx};
    step();
    wr_en = 1'b0;
  endtask

  task automatic data_window(input logic [9:0] x, input logic [9:0] y, input logic [8:0] md,
                             output int rd_cnt, output logic [13:0] addr);
    pixel_x = x; pixel_y = y; mem_data = md; refresh_data_in = 1'b1;
    step();
    step();
    rd_cnt = int'(mem_rd);
    addr = mem_addr;
    refresh_data_in = 1'b0;
    step();
    rd_cnt += int'(mem_rd);
  endtask

  task automatic vga_pulse(input logic [8:0] bg, output logic [8:0] color, output logic v1,
                           output logic v2, output int rd_cnt);
    bg_color = bg; refresh_vga_in = 1'b1;
    step();
    refresh_vga_in = 1'b0;
    color = color_out; v1 = color_valid; rd_cnt = int'(mem_rd);
    step();
    v2 = color_valid;
    rd_cnt += int'(mem_rd);
  endtask

  initial begin
    int          rd, rd2;
    logic [13:0] addr;
    logic [8:0]  color;
    logic        v1, v2;

    vecs[0] = '{10'd105, 10'd53,  9'h0A3, 9'h011, 1, 14'd865,  9'h0A3};
    vecs[1] = '{10'd120, 10'd50,  9'h1F0, 9'h055, 0, 14'd865,  9'h055};
    vecs[2] = '{10'd119, 10'd69,  9'h123, 9'h0F1, 1, 14'd1199, 9'h123};
    vecs[3] = '{10'd99,  10'd50,  9'h0AB, 9'h0F0, 0, 14'd1199, 9'h0F0};
    vecs[4] = '{10'd310, 10'd310, 9'h1C7, 9'h001, 1, 14'd610,  9'h1C7};
    vecs[5] = '{10'd324, 10'd306, 9'h0AA, 9'h002, 1, 14'd2039, 9'h0AA};
    vecs[6] = '{10'd5,   10'd5,   9'h077, 9'h1AB, 0, 14'd2039, 9'h1AB};
    vecs[7] = '{10'd100, 10'd70,  9'h066, 9'h003, 0, 14'd2039, 9'h003};
    vecs[8] = '{10'd105, 10'd53,  9'h1FF, 9'h007, 1, 14'd865,  TranspExp};

    reset = 1'b0; refresh_data_in = 1'b0; refresh_vga_in = 1'b0;
    pixel_x = '0; pixel_y = '0; wr_en = 1'b0; wr_slot = '0; wr_data = '0;
    bg_color = '0; mem_data = '0;
    repeat (3) step();
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_color_out", 32'(color_out), 0);
    check("rst_color_valid", 32'(color_valid), 0);
    reset = 1'b1;
    step();

    write_slot(3'd0, 1'b1, 5'd2, 10'd100, 10'd50);
    write_slot(3'd1, 1'b1, 5'd1, 10'd300, 10'd300);
    write_slot(3'd2, 1'b0, 5'd3, 10'd0,   10'd0);
    write_slot(3'd3, 1'b1, 5'd5, 10'd305, 10'd305);

    for (int i = 0; i < 9; i++) begin
      data_window(vecs[i].x, vecs[i].y, vecs[i].md, rd, addr);
      vga_pulse(vecs[i].bg, color, v1, v2, rd2);
      check($sformatf("v%0d_rd_count", i), 32'(rd + rd2), 32'(vecs[i].rd));
      check($sformatf("v%0d_mem_addr", i), 32'(addr), 32'(vecs[i].addr));
      check($sformatf("v%0d_color", i), 32'(color), 32'(vecs[i].color));
      check($sformatf("v%0d_valid_pulse", i), 32'(v1), 1);
      check($sformatf("v%0d_valid_drop", i), 32'(v2), 0);
    end

    // Output strobe with no data window: hit already cleared, background shown
    vga_pulse(9'h0C3, color, v1, v2, rd);
    check("novga_color", 32'(color), 32'h0C3);
    check("novga_valid", 32'(v1), 1);
    check("novga_rd", 32'(rd), 0);

    // Out-of-range slot index is ignored and must not alias slot 0
    write_slot(3'd4, 1'b1, 5'd0, 10'd500, 10'd500);
    data_window(10'd505, 10'd505, 9'h011, rd, addr);
    vga_pulse(9'h0DD, color, v1, v2, rd2);
    check("slot4_rd", 32'(rd + rd2), 0);
    check("slot4_color", 32'(color), 32'h0DD);
    data_window(10'd105, 10'd53, 9'h011, rd, addr);
    vga_pulse(9'h000, color, v1, v2, rd2);
    check("slot0_kept_addr", 32'(addr), 865);
    check("slot0_kept_color", 32'(color), 32'h011);

    // Sprite crossing x/y=1023 must not wrap
    write_slot(3'd2, 1'b1, 5'd0, 10'd1015, 10'd1015);
    data_window(10'd1020, 10'd1023, 9'h0C0, rd, addr);
    vga_pulse(9'h000, color, v1, v2, rd2);
    check("edge_rd", 32'(rd), 1);
    check("edge_addr", 32'(addr), 165);
    check("edge_color", 32'(color), 32'h0C0);

    // Output and data strobes in the same cycle
    data_window(10'd105, 10'd53, 9'h0A3, rd, addr);
    pixel_x = 10'd310; pixel_y = 10'd310; mem_data = 9'h1C7; bg_color = 9'h000;
    refresh_data_in = 1'b1; refresh_vga_in = 1'b1;
    step();
    refresh_vga_in = 1'b0;
    check("both_color", 32'(color_out), 32'h0A3);
    check("both_valid", 32'(color_valid), 1);
    step();
    refresh_data_in = 1'b0;
    check("both_next_rd", 32'(mem_rd), 1);
    check("both_next_addr", 32'(mem_addr), 610);
    step();
    vga_pulse(9'h000, color, v1, v2, rd);
    check("both_next_color", 32'(color), 32'h1C7);

    // Long data window: HOLD ignores later mem_data and issues no second read
    pixel_x = 10'd119; pixel_y = 10'd69; mem_data = 9'h155; refresh_data_in = 1'b1;
    rd = 0;
    step();
    step();
    rd += int'(mem_rd);
    addr = mem_addr;
    step();
    mem_data = 9'h0EE;
    rd += int'(mem_rd);
    step();
    rd += int'(mem_rd);
    step();
    refresh_data_in = 1'b0;
    rd += int'(mem_rd);
    step();
    vga_pulse(9'h000, color, v1, v2, rd2);
    check("hold_rd", 32'(rd + rd2), 1);
    check("hold_addr", 32'(addr), 1199);
    check("hold_color", 32'(color), 32'h155);

    // Slot write during ADDR applies from the next pixel
    pixel_x = 10'd105; pixel_y = 10'd53; mem_data = 9'h0A5; refresh_data_in = 1'b1;
    step();
    wr_en = 1'b1; wr_slot = 3'd0; wr_data = '0;
    step();
    wr_en = 1'b0; refresh_data_in = 1'b0;
    check("wraddr_rd", 32'(mem_rd), 1);
    step();
    vga_pulse(9'h000, color, v1, v2, rd);
    check("wraddr_color", 32'(color), 32'h0A5);
    data_window(10'd105, 10'd53, 9'h0A5, rd, addr);
    vga_pulse(9'h111, color, v1, v2, rd2);
    check("wraddr_next_rd", 32'(rd + rd2), 0);
    check("wraddr_next_color", 32'(color), 32'h111);

    // Reset between READ and output strobe aborts the pixel
    data_window(10'd310, 10'd310, 9'h1C7, rd, addr);
    reset = 1'b0; refresh_vga_in = 1'b1; bg_color = 9'h0FF;
    step();
    reset = 1'b1; refresh_vga_in = 1'b0;
    check("rstmid_valid", 32'(color_valid), 0);
    check("rstmid_color", 32'(color_out), 0);
    check("rstmid_addr", 32'(mem_addr), 0);
    step();
    check("rstmid_valid2", 32'(color_valid), 0);
    data_window(10'd310, 10'd310, 9'h1C7, rd, addr);
    check("rstmid_slots_clear", 32'(rd), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
